counter_chain: RTL and testbench

- Parametrised cascaded multi-digit counter, the successor to the fixed 4-stage counter chain feeding the seven-segment display.
- NDIG identical digit stages of modulus MOD, all sharing one synchronous datapath.
- Adds over the fixed chain: run-time up/down direction, wrap-or-saturate mode, parallel load of all digits, whole-chain terminal-count flag, and a built-in digit scan multiplexer for the display.

---
 rtl/counter_chain.sv | 113 +++++++++++
 tb/tb_counter_chain.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/counter_chain.sv
// rtl/counter_chain.sv - cascaded multi-digit up/down counter with scan mux
module counter_chain #(
  parameter int NDIG     = 4,
  parameter int DW       = 4,
  parameter int MOD      = 10,
  parameter int SCAN_DIV = 27000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               up,
  input  logic               sat,
  input  logic               load,
  input  logic [NDIG*DW-1:0] di,
  output logic [NDIG*DW-1:0] q,
  output logic               tc,
  output logic               ceo,
  output logic [NDIG-1:0]    an,
  output logic [DW-1:0]      dval
);

  localparam int IW    = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int SW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int MODM1 = MOD - 1;
  localparam int DIVM1 = SCAN_DIV - 1;
  localparam int NDM1  = NDIG - 1;

  localparam logic [DW-1:0] DMAX     = MODM1[DW-1:0];
  localparam logic [SW-1:0] DIV_LAST = DIVM1[SW-1:0];
  localparam logic [IW-1:0] IDX_LAST = NDM1[IW-1:0];

  logic [DW-1:0]   dig_q [NDIG];
  logic [DW-1:0]   dig_d [NDIG];
  logic [NDIG-1:0] term;
  logic [NDIG-1:0] step_en;
  logic            count_go;
  logic [SW-1:0]   div_q, div_d;
  logic [IW-1:0]   idx_q, idx_d;

  // Per-digit terminal detect and ripple-free step enables (digit k steps when all lower digits are terminal)
  always_comb begin
    logic run;
    term    = '0;
    step_en = '0;
    run     = 1'b1;
    for (int k = 0; k < NDIG; k++) begin
      term[k]    = up ? (dig_q[k] == DMAX) : (dig_q[k] == '0);
      step_en[k] = run;
      run        = run & term[k];
    end
  end

  assign tc       = &term;
  assign ceo      = ce & ~load & tc & ~sat;
  assign count_go = ce & ~load & ~(sat & tc);

  // Next digit values: load with clamp to MOD-1, otherwise modulo-MOD step or hold
  always_comb begin
    for (int k = 0; k < NDIG; k++) begin
      dig_d[k] = dig_q[k];
      if (load) begin
        if (di[k*DW +: DW] > DMAX) dig_d[k] = DMAX;
        else                       dig_d[k] = di[k*DW +: DW];
      end else if (count_go && step_en[k]) begin
        if (up) dig_d[k] = (dig_q[k] == DMAX) ? '0 : dig_q[k] + 1'b1;
        else    dig_d[k] = (dig_q[k] == '0) ? DMAX : dig_q[k] - 1'b1;
      end
    end
  end

  // Digit registers
  always_ff @(posedge clk) begin
    for (int k = 0; k < NDIG; k++) begin
      if (!rst) dig_q[k] <= '0;
      else      dig_q[k] <= dig_d[k];
    end
  end

  // Pack digits onto the flat count output
  always_comb begin
    q = '0;
    for (int k = 0; k < NDIG; k++) q[k*DW +: DW] = dig_q[k];
  end

  // Free-running scan divider and digit index, independent of counting
  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Scan state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

  // One-cold digit select and selected digit value
  always_comb begin
    an        = '1;
    an[idx_q] = 1'b0;
    dval      = dig_q[idx_q];
  end

endmodule

// File: tb/tb_counter_chain.sv
// tb/tb_counter_chain.sv - directed self-checking bench for counter_chain
module tb_counter_chain;

  logic        clk = 1'b0;
  logic        rst, ce, up, sat, load;
  logic [15:0] di;
  logic [15:0] q_a, q_b;
  logic        tc_a, tc_b, ceo_a, ceo_b;
  logic [3:0]  an_a, an_b, dval_a, dval_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  counter_chain #(.NDIG(4), .DW(4), .MOD(10), .SCAN_DIV(4)) u_bcd (
    .clk(clk), .rst(rst), .ce(ce), .up(up), .sat(sat), .load(load), .di(di),
    .q(q_a), .tc(tc_a), .ceo(ceo_a), .an(an_a), .dval(dval_a)
  );

  counter_chain #(.NDIG(4), .DW(4), .MOD(16), .SCAN_DIV(1)) u_bin (
    .clk(clk), .rst(rst), .ce(ce), .up(up), .sat(sat), .load(load), .di(di),
    .q(q_b), .tc(tc_b), .ceo(ceo_b), .an(an_b), .dval(dval_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; ce = 1'b0; load = 1'b0;
    step();
    rst = 1'b1;
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; di = v;
    step();
    load = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    up = 1'b1; sat = 1'b0;
    do_reset();
    n_cmp++; if (q_a !== 16'h0000) begin n_fail++; $display("FAIL reset_q act=%h exp=0000", q_a); end
    n_cmp++; if (an_a !== 4'b1110) begin n_fail++; $display("FAIL reset_an act=%b exp=1110", an_a); end
    n_cmp++; if (dval_a !== 4'h0) begin n_fail++; $display("FAIL reset_dval act=%h exp=0", dval_a); end
    n_cmp++; if (tc_a !== 1'b0) begin n_fail++; $display("FAIL reset_tc_up act=%b exp=0", tc_a); end
    up = 1'b0; #1;
    n_cmp++; if (tc_a !== 1'b1) begin n_fail++; $display("FAIL reset_tc_down act=%b exp=1", tc_a); end
    n_cmp++; if (ceo_a !== 1'b0) begin n_fail++; $display("FAIL reset_ceo act=%b exp=0", ceo_a); end
    up = 1'b1; #1;
  endtask

  task automatic test_wrap_up();
    up = 1'b1; sat = 1'b0;
    do_load(16'h9998);
    n_cmp++; if (q_a !== 16'h9998) begin n_fail++; $display("FAIL wrap_load act=%h exp=9998", q_a); end
    ce = 1'b1; #1;
    n_cmp++; if (ceo_a !== 1'b0) begin n_fail++; $display("FAIL wrap_ceo0 act=%b exp=0", ceo_a); end
    step();
    n_cmp++; if (q_a !== 16'h9999) begin n_fail++; $display("FAIL wrap_q1 act=%h exp=9999", q_a); end
    n_cmp++; if (tc_a !== 1'b1) begin n_fail++; $display("FAIL wrap_tc act=%b exp=1", tc_a); end
    n_cmp++; if (ceo_a !== 1'b1) begin n_fail++; $display("FAIL wrap_ceo1 act=%b exp=1", ceo_a); end
    step();
    n_cmp++; if (q_a !== 16'h0000) begin n_fail++; $display("FAIL wrap_q2 act=%h exp=0000", q_a); end
    n_cmp++; if (ceo_a !== 1'b0) begin n_fail++; $display("FAIL wrap_ceo2 act=%b exp=0", ceo_a); end
    step();
    n_cmp++; if (q_a !== 16'h0001) begin n_fail++; $display("FAIL wrap_q3 act=%h exp=0001", q_a); end
    ce = 1'b0; #1;
  endtask

  task automatic test_down();
    sat = 1'b0;
    do_reset();
    up = 1'b0; ce = 1'b1; #1;
    n_cmp++; if (tc_a !== 1'b1) begin n_fail++; $display("FAIL down_tc act=%b exp=1", tc_a); end
    n_cmp++; if (ceo_a !== 1'b1) begin n_fail++; $display("FAIL down_ceo act=%b exp=1", ceo_a); end
    step();
    n_cmp++; if (q_a !== 16'h9999) begin n_fail++; $display("FAIL down_q1 act=%h exp=9999", q_a); end
    n_cmp++; if (q_b !== 16'hFFFF) begin n_fail++; $display("FAIL down_bin_q1 act=%h exp=FFFF", q_b); end
    n_cmp++; if (ceo_a !== 1'b0) begin n_fail++; $display("FAIL down_ceo2 act=%b exp=0", ceo_a); end
    step();
    n_cmp++; if (q_a !== 16'h9998) begin n_fail++; $display("FAIL down_q2 act=%h exp=9998", q_a); end
    n_cmp++; if (q_b !== 16'hFFFE) begin n_fail++; $display("FAIL down_bin_q2 act=%h exp=FFFE", q_b); end
    ce = 1'b0; up = 1'b1; #1;
  endtask

  task automatic test_saturate();
    up = 1'b1; sat = 1'b1;
    do_load(16'h9999);
    ce = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (tc_a !== 1'b1) begin n_fail++; $display("FAIL sat_tc[%0d] act=%b exp=1", i, tc_a); end
      n_cmp++; if (ceo_a !== 1'b0) begin n_fail++; $display("FAIL sat_ceo[%0d] act=%b exp=0", i, ceo_a); end
      step();
      n_cmp++; if (q_a !== 16'h9999) begin n_fail++; $display("FAIL sat_q[%0d] act=%h exp=9999", i, q_a); end
    end
    up = 1'b0; #1;
    n_cmp++; if (tc_a !== 1'b0) begin n_fail++; $display("FAIL sat_dir_tc act=%b exp=0", tc_a); end
    step();
    n_cmp++; if (q_a !== 16'h9998) begin n_fail++; $display("FAIL sat_dir_q act=%h exp=9998", q_a); end
    ce = 1'b0; sat = 1'b0; up = 1'b1; #1;
  endtask

  task automatic test_load_clamp();
    up = 1'b1; sat = 1'b0;
    load = 1'b1; ce = 1'b1; di = 16'hF3A7; #1;
    n_cmp++; if (ceo_a !== 1'b0) begin n_fail++; $display("FAIL clamp_ceo act=%b exp=0", ceo_a); end
    step();
    n_cmp++; if (q_a !== 16'h9397) begin n_fail++; $display("FAIL clamp_q act=%h exp=9397", q_a); end
    n_cmp++; if (q_b !== 16'hF3A7) begin n_fail++; $display("FAIL clamp_bin_q act=%h exp=F3A7", q_b); end
    load = 1'b0; ce = 1'b0; #1;
  endtask

  task automatic test_mid_reset();
    up = 1'b1; sat = 1'b0;
    do_load(16'h0456);
    ce = 1'b1;
    step(); step();
    n_cmp++; if (q_a !== 16'h0458) begin n_fail++; $display("FAIL midrst_pre act=%h exp=0458", q_a); end
    rst = 1'b0; load = 1'b1; di = 16'h1234;
    step();
    n_cmp++; if (q_a !== 16'h0000) begin n_fail++; $display("FAIL midrst_q act=%h exp=0000", q_a); end
    n_cmp++; if (an_a !== 4'b1110) begin n_fail++; $display("FAIL midrst_an act=%b exp=1110", an_a); end
    n_cmp++; if (dval_a !== 4'h0) begin n_fail++; $display("FAIL midrst_dval act=%h exp=0", dval_a); end
    rst = 1'b1; load = 1'b0;
    step();
    n_cmp++; if (q_a !== 16'h0001) begin n_fail++; $display("FAIL midrst_resume act=%h exp=0001", q_a); end
    ce = 1'b0; #1;
  endtask

  task automatic test_scan();
    logic [3:0] exp_an;
    logic [3:0] exp_dv;
    int idx;
    up = 1'b1; sat = 1'b0;
    do_reset();
    do_load(16'h4321);
    for (int k = 1; k <= 20; k++) begin
      idx    = (k / 4) % 4;
      exp_an = ~(4'b0001 << idx);
      exp_dv = 4'(idx + 1);
      n_cmp++; if (an_a !== exp_an) begin n_fail++; $display("FAIL scan_an k=%0d act=%b exp=%b", k, an_a, exp_an); end
      n_cmp++; if (dval_a !== exp_dv) begin n_fail++; $display("FAIL scan_dval k=%0d act=%h exp=%h", k, dval_a, exp_dv); end
      idx    = k % 4;
      exp_an = ~(4'b0001 << idx);
      exp_dv = 4'(idx + 1);
      n_cmp++; if (an_b !== exp_an) begin n_fail++; $display("FAIL scan1_an k=%0d act=%b exp=%b", k, an_b, exp_an); end
      n_cmp++; if (dval_b !== exp_dv) begin n_fail++; $display("FAIL scan1_dval k=%0d act=%h exp=%h", k, dval_b, exp_dv); end
      step();
    end
  endtask

  task automatic test_bin_wrap();
    up = 1'b1; sat = 1'b0;
    do_load(16'hFFFF);
    n_cmp++; if (q_a !== 16'h9999) begin n_fail++; $display("FAIL binw_bcd_clamp act=%h exp=9999", q_a); end
    ce = 1'b1; #1;
    n_cmp++; if (tc_b !== 1'b1) begin n_fail++; $display("FAIL binw_tc act=%b exp=1", tc_b); end
    n_cmp++; if (ceo_b !== 1'b1) begin n_fail++; $display("FAIL binw_ceo act=%b exp=1", ceo_b); end
    step();
    n_cmp++; if (q_b !== 16'h0000) begin n_fail++; $display("FAIL binw_q act=%h exp=0000", q_b); end
    n_cmp++; if (q_a !== 16'h0000) begin n_fail++; $display("FAIL binw_bcd_q act=%h exp=0000", q_a); end
    ce = 1'b0; #1;
  endtask

  initial begin
    rst = 1'b0; ce = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0; di = '0;
    #2;
    test_reset();
    test_wrap_up();
    test_down();
    test_saturate();
    test_load_clamp();
    test_mid_reset();
    test_scan();
    test_bin_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
